// File: rtl/mac_stream_engine.sv
// Two-stage elastic multiply/shift/saturate datapath between the a-source and d-sink streamers.
// Counts accepted outputs per tile and pulses tile_done_o on the handshake that completes a tile.
module mac_stream_engine #(
    parameter int DATA_W = 32,
    parameter int MU_W   = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [MU_W-1:0]   mu_i,
    input  logic [4:0]        shift_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    output logic [DATA_W-1:0] d_data_o,
    output logic              d_valid_o,
    input  logic              d_ready_i,
    output logic [CNT_W-1:0]  cnt_out_o,
    output logic              tile_done_o
);

    localparam int PROD_W = DATA_W + MU_W;
    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(MU_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(MU_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic                     r_s1_vld;
    logic signed [PROD_W-1:0] r_s1_prod;
    logic [4:0]               r_s1_shift;
    logic                     r_s2_vld;
    logic [DATA_W-1:0]        r_d_data;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_s2_adv;
    logic                     w_a_hs;
    logic                     w_d_hs;
    logic [CNT_W-1:0]         w_cnt_next;
    logic [PROD_W-1:0]        w_a_ext;
    logic [PROD_W-1:0]        w_mu_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shifted;
    logic [DATA_W-1:0]        w_sat;

    // Valid/ready: a word moves across an interface in the cycle where valid and ready
    // are both high at the rising edge; valid never drops until that happens.
    assign w_s2_adv   = enable_i & r_s1_vld & (~r_s2_vld | d_ready_i);
    assign a_ready_o  = rst_ni & enable_i & (len_i != '0) & (~r_s1_vld | w_s2_adv);
    assign w_a_hs     = a_valid_i & a_ready_o;
    assign w_d_hs     = r_s2_vld & d_ready_i;
    assign w_cnt_next = (r_cnt == len_i) ? CNT_W'(1) : r_cnt + CNT_W'(1);

    // Product carried at full width so saturation sees the true value.
    assign w_a_ext   = {{MU_W{a_data_i[DATA_W-1]}}, a_data_i};
    assign w_mu_ext  = {{DATA_W{mu_i[MU_W-1]}}, mu_i};
    assign w_prod    = $signed(w_a_ext) * $signed(w_mu_ext);
    assign w_shifted = r_s1_prod >>> r_s1_shift;

    always_comb begin
        w_sat = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_sat = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_vld   <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_shift <= '0;
            r_s2_vld   <= 1'b0;
            r_d_data   <= '0;
            r_cnt      <= '0;
        end else if (clear_i) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_a_hs) begin
                r_s1_vld   <= 1'b1;
                r_s1_prod  <= w_prod;
                r_s1_shift <= shift_i;
            end else if (w_s2_adv) begin
                r_s1_vld <= 1'b0;
            end
            // A presented output still drains while frozen; only refill needs enable_i.
            if (w_s2_adv) begin
                r_s2_vld <= 1'b1;
                r_d_data <= w_sat;
            end else if (w_d_hs) begin
                r_s2_vld <= 1'b0;
            end
            if (w_d_hs) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign d_data_o    = r_d_data;
    assign d_valid_o   = r_s2_vld;
    assign cnt_out_o   = r_cnt;
    assign tile_done_o = w_d_hs & ~clear_i & (w_cnt_next == len_i);

endmodule
